bridge_dataslot_reader: RTL and testbench

- Responder for APF bridge reads of one save-data dataslot window. It is the read-side counterpart to the dataslot write monitoring.
- The core fills an internal word RAM, then arms the block with a length. The block serves the host's bridge reads from that RAM and tracks sequential read progress.
- It signals `done` when the host has read the armed length. Core writes are locked out while the host is reading.

---
 rtl/bridge_dataslot_reader_if.sv | 26 ++
 rtl/bridge_dataslot_reader.sv | 188 ++++++++++++++++++
 tb/tb_bridge_dataslot_reader.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/bridge_dataslot_reader_if.sv
// Bridge read bus between the APF host side and the dataslot reader.
//   bridge_rd       : read strobe, one cycle per request (host -> reader)
//   bridge_addr     : byte address of the request (host -> reader)
//   bridge_rd_data  : read data, valid while bridge_rd_valid is high (reader -> host)
//   bridge_rd_valid : one-cycle strobe marking returned data (reader -> host)
// master = host side, slave = reader side.
interface bridge_dataslot_reader_if;
  logic        bridge_rd;
  logic [31:0] bridge_addr;
  logic [31:0] bridge_rd_data;
  logic        bridge_rd_valid;

  modport master (
    output bridge_rd,
    output bridge_addr,
    input  bridge_rd_data,
    input  bridge_rd_valid
  );

  modport slave (
    input  bridge_rd,
    input  bridge_addr,
    output bridge_rd_data,
    output bridge_rd_valid
  );
endinterface

// File: rtl/bridge_dataslot_reader.sv
// Responder for APF bridge reads of one save-data dataslot window.
// The core fills an internal word RAM, then arms a session with a length.
// Host bridge reads are served from the RAM with a fixed 2-cycle latency;
// in-order reads starting at word 0 are counted and `done` pulses together
// with the valid of the last word of the session. Core writes are refused
// while the host is actively reading.
// Ports:
//   clk, reset_n            : clock, synchronous active-low reset
//   bus (slave)             : bridge read bus (rd, addr, rd_data, rd_valid)
//   core_wr/core_addr/core_wr_data/core_wr_accept : core RAM write port
//   arm, arm_len_words      : session start pulse and length in words
//   busy, done, read_count  : session status
module bridge_dataslot_reader #(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          DEPTH       = 1024,
  parameter int          ENDIAN_SWAP = 1,
  localparam int         AW          = $clog2(DEPTH)
) (
  input  logic                     clk,
  input  logic                     reset_n,
  bridge_dataslot_reader_if.slave  bus,
  input  logic                     core_wr,
  input  logic [AW-1:0]            core_addr,
  input  logic [31:0]              core_wr_data,
  output logic                     core_wr_accept,
  input  logic                     arm,
  input  logic [AW:0]              arm_len_words,
  output logic                     busy,
  output logic                     done,
  output logic [AW:0]              read_count
);

  // Parameter sanity: the window must be a power-of-two size and naturally aligned.
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("bridge_dataslot_reader: DEPTH must be a power of two >= 2");
  end
  if ((BASE_ADDR & 32'(DEPTH * 4 - 1)) != 32'd0) begin : g_bad_base
    $error("bridge_dataslot_reader: BASE_ADDR must be aligned to DEPTH*4 bytes");
  end

  localparam logic [AW:0] DEPTH_W = (AW + 1)'(DEPTH);
  localparam logic [AW:0] ONE_W   = (AW + 1)'(1);
  localparam logic [AW:0] ZERO_W  = (AW + 1)'(0);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_READING = 2'd2
  } state_t;

  function automatic logic [31:0] swap_bytes(input logic [31:0] d);
    return {d[7:0], d[15:8], d[23:16], d[31:24]};
  endfunction

  function automatic logic [31:0] out_order(input logic [31:0] d);
    return (ENDIAN_SWAP != 0) ? swap_bytes(d) : d;
  endfunction

  logic [31:0]   mem_r [DEPTH];
  logic [31:0]   ram_q_r;
  logic          hit_s;
  logic [AW-1:0] rd_idx_s;
  logic          hit_r;
  logic [AW-1:0] idx_r;
  logic [31:0]   rd_data_r;
  logic          rd_valid_r;

  state_t        state_r, state_nxt_s;
  logic [AW:0]   count_r, count_nxt_s;
  logic [AW:0]   len_r, len_nxt_s;
  logic          done_r, done_nxt_s;
  logic [AW:0]   count_inc_s;

  assign hit_s    = bus.bridge_rd
                 && (bus.bridge_addr[31:AW+2] == BASE_ADDR[31:AW+2])
                 && (bus.bridge_addr[1:0] == 2'b00);
  assign rd_idx_s = bus.bridge_addr[AW+1:2];

  assign core_wr_accept      = core_wr && (state_r != ST_READING);
  assign busy                = (state_r != ST_IDLE);
  assign done                = done_r;
  assign read_count          = count_r;
  assign bus.bridge_rd_data  = rd_data_r;
  assign bus.bridge_rd_valid = rd_valid_r;
  assign count_inc_s         = count_r + ONE_W;

  // RAM write port; contents survive reset.
  always_ff @(posedge clk) begin
    if (core_wr_accept) begin
      mem_r[core_addr] <= core_wr_data;
    end
  end

  // Stage 1: capture the hit and read the RAM. Nonblocking write above makes
  // a same-word same-cycle collision read-first.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      hit_r   <= 1'b0;
      idx_r   <= '0;
      ram_q_r <= 32'd0;
    end else begin
      hit_r   <= hit_s;
      idx_r   <= rd_idx_s;
      ram_q_r <= mem_r[rd_idx_s];
    end
  end

  // Stage 2: registered read data; data holds on cycles without a hit.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rd_data_r  <= 32'd0;
      rd_valid_r <= 1'b0;
    end else begin
      rd_valid_r <= hit_r;
      if (hit_r) begin
        rd_data_r <= out_order(ram_q_r);
      end
    end
  end

  // Session state register; updated from stage 1 so done lines up with the valid.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_r <= ST_IDLE;
      count_r <= ZERO_W;
      len_r   <= ZERO_W;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      count_r <= count_nxt_s;
      len_r   <= len_nxt_s;
      done_r  <= done_nxt_s;
    end
  end

  // Session next-state: arming, in-order counting and completion.
  always_comb begin
    state_nxt_s = state_r;
    count_nxt_s = count_r;
    len_nxt_s   = len_r;
    done_nxt_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (arm) begin
          if (arm_len_words == ZERO_W) begin
            done_nxt_s = 1'b1;
          end else begin
            len_nxt_s   = (arm_len_words > DEPTH_W) ? DEPTH_W : arm_len_words;
            count_nxt_s = ZERO_W;
            state_nxt_s = ST_ARMED;
          end
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_ARMED: begin
        if (hit_r && (idx_r == '0)) begin
          count_nxt_s = ONE_W;
          if (len_r == ONE_W) begin
            state_nxt_s = ST_IDLE;
            done_nxt_s  = 1'b1;
          end else begin
            state_nxt_s = ST_READING;
          end
        end else begin
          state_nxt_s = ST_ARMED;
        end
      end
      ST_READING: begin
        if (hit_r && ({1'b0, idx_r} == count_r)) begin
          count_nxt_s = count_inc_s;
          if (count_inc_s == len_r) begin
            state_nxt_s = ST_IDLE;
            done_nxt_s  = 1'b1;
          end else begin
            state_nxt_s = ST_READING;
          end
        end else begin
          state_nxt_s = ST_READING;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_bridge_dataslot_reader.sv
// Self-checking bench for bridge_dataslot_reader (BASE 0x4000_0000, DEPTH 16,
// byte swap on). Table-driven single reads plus hand-written session sequences.
module tb_bridge_dataslot_reader;
  localparam logic [31:0] BASE = 32'h4000_0000;
  localparam int          DEP  = 16;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        core_wr;
  logic [3:0]  core_addr;
  logic [31:0] core_wr_data;
  logic        core_wr_accept;
  logic        arm;
  logic [4:0]  arm_len_words;
  logic        busy;
  logic        done;
  logic [4:0]  read_count;

  bridge_dataslot_reader_if bus ();

  bridge_dataslot_reader #(
    .BASE_ADDR   (BASE),
    .DEPTH       (DEP),
    .ENDIAN_SWAP (1)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .bus            (bus),
    .core_wr        (core_wr),
    .core_addr      (core_addr),
    .core_wr_data   (core_wr_data),
    .core_wr_accept (core_wr_accept),
    .arm            (arm),
    .arm_len_words  (arm_len_words),
    .busy           (busy),
    .done           (done),
    .read_count     (read_count)
  );

  always #5 clk = ~clk;

  int errors_n = 0;
  int checks_n = 0;
  logic [31:0] model_mem [DEP];

  typedef struct {
    logic [31:0] addr;
    logic        exp_valid;
    logic [31:0] exp_data;
    string       name;
  } vec_t;
  vec_t vecs [8];

  function automatic logic [31:0] swap32(input logic [31:0] d);
    logic [31:0] r;
    for (int b = 0; b < 4; b++) r[8*b +: 8] = d[8*(3-b) +: 8];
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks_n++;
    if (act !== exp) begin
      errors_n++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One isolated read; checks latency, data, count and done at the valid cycle.
  task automatic read_check(input logic [31:0] addr, input logic exp_valid,
                            input logic [31:0] exp_data, input logic [4:0] exp_count,
                            input logic exp_done, input string name);
    bus.bridge_rd   = 1'b1;
    bus.bridge_addr = addr;
    tick();
    bus.bridge_rd = 1'b0;
    chk({name, ".early_valid"}, {31'd0, bus.bridge_rd_valid}, 32'd0);
    tick();
    chk({name, ".valid"}, {31'd0, bus.bridge_rd_valid}, {31'd0, exp_valid});
    chk({name, ".data"}, bus.bridge_rd_data, exp_data);
    chk({name, ".count"}, {27'd0, read_count}, {27'd0, exp_count});
    chk({name, ".done"}, {31'd0, done}, {31'd0, exp_done});
  endtask

  task automatic arm_session(input logic [4:0] len);
    arm           = 1'b1;
    arm_len_words = len;
    tick();
    arm = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{32'h4000_000C, 1'b1, 32'h4433_2211, "basic_w3"};
    vecs[1] = '{32'h4000_0000, 1'b1, 32'h0003_0201, "w0"};
    vecs[2] = '{32'h4000_003C, 1'b1, 32'h0F03_0201, "w15"};
    vecs[3] = '{32'h4000_0040, 1'b0, 32'h0F03_0201, "oow_hi"};
    vecs[4] = '{32'h4000_0002, 1'b0, 32'h0F03_0201, "misalign"};
    vecs[5] = '{32'h3FFF_FFFC, 1'b0, 32'h0F03_0201, "oow_lo"};
    vecs[6] = '{32'h4000_0024, 1'b1, 32'h0903_0201, "w9"};
    vecs[7] = '{32'h5000_000C, 1'b0, 32'h0903_0201, "oow_far"};

    reset_n         = 1'b0;
    bus.bridge_rd   = 1'b0;
    bus.bridge_addr = 32'd0;
    core_wr         = 1'b0;
    core_addr       = 4'd0;
    core_wr_data    = 32'd0;
    arm             = 1'b0;
    arm_len_words   = 5'd0;
    tick();
    tick();
    reset_n = 1'b1;
    chk("rst.valid", {31'd0, bus.bridge_rd_valid}, 32'd0);
    chk("rst.data", bus.bridge_rd_data, 32'd0);
    chk("rst.done", {31'd0, done}, 32'd0);
    chk("rst.count", {27'd0, read_count}, 32'd0);
    chk("rst.busy", {31'd0, busy}, 32'd0);

    // Preload: word 3 is the reference pattern, others 0x010203ii.
    for (int i = 0; i < DEP; i++) begin
      model_mem[i] = (i == 3) ? 32'h1122_3344 : (32'h0102_0300 | 32'(i));
      core_wr      = 1'b1;
      core_addr    = 4'(i);
      core_wr_data = model_mem[i];
      #1;
      chk("preload.accept", {31'd0, core_wr_accept}, 32'd1);
      tick();
    end
    core_wr = 1'b0;

    for (int v = 0; v < 8; v++) begin
      read_check(vecs[v].addr, vecs[v].exp_valid, vecs[v].exp_data, 5'd0, 1'b0, vecs[v].name);
    end
    tick();
    chk("basic.valid_one_cycle", {31'd0, bus.bridge_rd_valid}, 32'd0);

    // Sequential session, back-to-back reads 0..3.
    arm_session(5'd4);
    chk("seq.busy_armed", {31'd0, busy}, 32'd1);
    chk("seq.count0", {27'd0, read_count}, 32'd0);
    bus.bridge_rd   = 1'b1;
    bus.bridge_addr = BASE;
    for (int k = 1; k <= 6; k++) begin
      logic exp_v;
      int   exp_c;
      tick();
      bus.bridge_rd   = (k <= 3);
      bus.bridge_addr = BASE + 32'(k * 4);
      exp_v = (k >= 2 && k <= 5);
      exp_c = (k < 2) ? 0 : ((k - 1 > 4) ? 4 : k - 1);
      chk($sformatf("seq.valid%0d", k), {31'd0, bus.bridge_rd_valid}, {31'd0, exp_v});
      if (exp_v) chk($sformatf("seq.data%0d", k), bus.bridge_rd_data, swap32(model_mem[k-2]));
      chk($sformatf("seq.count%0d", k), {27'd0, read_count}, 32'(exp_c));
      chk($sformatf("seq.done%0d", k), {31'd0, done}, {31'd0, (k == 5)});
      chk($sformatf("seq.busy%0d", k), {31'd0, busy}, {31'd0, (k <= 4)});
    end
    core_wr      = 1'b1;
    core_addr    = 4'd5;
    core_wr_data = 32'hCAFE_F00D;
    #1;
    chk("seq.accept_after", {31'd0, core_wr_accept}, 32'd1);
    tick();
    core_wr      = 1'b0;
    model_mem[5] = 32'hCAFE_F00D;
    read_check(BASE + 32'h14, 1'b1, 32'h0DF0_FECA, 5'd4, 1'b0, "idle_hold_count");

    // Lockout session: ARMED ignores idx!=0, READING refuses core writes.
    arm_session(5'd4);
    read_check(BASE + 32'h08, 1'b1, 32'h0203_0201, 5'd0, 1'b0, "armed_idx2");
    read_check(BASE + 32'h00, 1'b1, 32'h0003_0201, 5'd1, 1'b0, "lock_r0");
    core_wr      = 1'b1;
    core_addr    = 4'd2;
    core_wr_data = 32'hDEAD_BEEF;
    #1;
    chk("lock.accept", {31'd0, core_wr_accept}, 32'd0);
    tick();
    core_wr = 1'b0;
    read_check(BASE + 32'h04, 1'b1, 32'h0103_0201, 5'd2, 1'b0, "lock_r1");
    read_check(BASE + 32'h04, 1'b1, 32'h0103_0201, 5'd2, 1'b0, "lock_reread1");
    read_check(BASE + 32'h08, 1'b1, 32'h0203_0201, 5'd3, 1'b0, "lock_r2_old");
    read_check(BASE + 32'h0C, 1'b1, 32'h4433_2211, 5'd4, 1'b1, "lock_r3");
    chk("lock.busy_end", {31'd0, busy}, 32'd0);

    // Zero-length arm.
    arm_session(5'd0);
    chk("len0.done", {31'd0, done}, 32'd1);
    chk("len0.busy", {31'd0, busy}, 32'd0);
    tick();
    chk("len0.done_off", {31'd0, done}, 32'd0);
    chk("len0.busy2", {31'd0, busy}, 32'd0);

    // Over-length arm clamps to DEPTH.
    arm_session(5'd20);
    chk("clamp.busy", {31'd0, busy}, 32'd1);
    for (int i = 0; i < DEP; i++) begin
      read_check(BASE + 32'(i * 4), 1'b1, swap32(model_mem[i]), 5'(i + 1), (i == DEP - 1),
                 $sformatf("clamp_r%0d", i));
    end
    chk("clamp.busy_end", {31'd0, busy}, 32'd0);
    tick();
    chk("clamp.count_hold", {27'd0, read_count}, 32'd16);

    // Reset mid-session with a read in flight.
    arm_session(5'd8);
    for (int i = 0; i < 3; i++) begin
      read_check(BASE + 32'(i * 4), 1'b1, swap32(model_mem[i]), 5'(i + 1), 1'b0,
                 $sformatf("mid_r%0d", i));
    end
    bus.bridge_rd   = 1'b1;
    bus.bridge_addr = BASE + 32'h0C;
    tick();
    bus.bridge_rd = 1'b0;
    reset_n       = 1'b0;
    tick();
    reset_n = 1'b1;
    chk("midrst.valid", {31'd0, bus.bridge_rd_valid}, 32'd0);
    chk("midrst.done", {31'd0, done}, 32'd0);
    chk("midrst.busy", {31'd0, busy}, 32'd0);
    chk("midrst.count", {27'd0, read_count}, 32'd0);
    tick();
    chk("midrst.valid2", {31'd0, bus.bridge_rd_valid}, 32'd0);
    chk("midrst.done2", {31'd0, done}, 32'd0);
    read_check(BASE + 32'h0C, 1'b1, 32'h4433_2211, 5'd0, 1'b0, "post_rst_ram");

    $display("Result: errors=%0d of %0d checks", errors_n, checks_n);
    $finish;
  end
endmodule
